// File: rtl/square_wave_meas_pkg.sv
// Shared types and constants for the square-wave period measurement block.
// Holds the FSM state encoding and the saturation ceiling helper.
package square_wave_meas_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } meas_state_e;

  // Largest value representable in 'width' bits, used as the counter ceiling.
  function automatic logic [31:0] sat_max(input int unsigned width);
    if (width >= 32) begin
      return '1;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, followed by one delayed
// copy so single-cycle rise/fall pulses can be derived in the i_clk domain.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_data,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_data};
    prev_d = level;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_rise = level & ~prev_q;
  assign o_fall = ~level & prev_q;

endmodule

// File: rtl/square_wave_meas.sv
// Measures high/low phase lengths of an asynchronous square wave in i_clk
// cycles, strobing one (on, off) pair per completed period; flags saturation and a stuck input.
module square_wave_meas
  import square_wave_meas_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_data,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_on_duration,
  output logic [WIDTH-1:0] o_off_duration,
  output logic             o_valid,
  output logic             o_overflow,
  output logic             o_stuck
);

  localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);

  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_detect (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_data (i_data),
    .o_rise (rise),
    .o_fall (fall)
  );

  meas_state_e      state_q,    state_d;
  logic [WIDTH-1:0] on_cnt_q,   on_cnt_d;
  logic [WIDTH-1:0] off_cnt_q,  off_cnt_d;
  logic [WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic [WIDTH-1:0] on_dur_q,   on_dur_d;
  logic [WIDTH-1:0] off_dur_q,  off_dur_d;
  logic             valid_q,    valid_d;
  logic             overflow_q, overflow_d;
  logic             stuck_q,    stuck_d;
  logic             sat_hit;

  always_comb begin
    state_d    = state_q;
    on_cnt_d   = on_cnt_q;
    off_cnt_d  = off_cnt_q;
    on_dur_d   = on_dur_q;
    off_dur_d  = off_dur_q;
    valid_d    = 1'b0;
    sat_hit    = 1'b0;

    if (rise || fall) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == CNT_MAX) begin
      idle_cnt_d = idle_cnt_q;
    end else begin
      idle_cnt_d = idle_cnt_q + CNT_ONE;
    end

    // The edge cycle is the first cycle of the new phase, so the counter
    // being closed is not incremented on that cycle.
    case (state_q)
      WAIT_RISE: begin
        if (rise) begin
          on_cnt_d = CNT_ONE;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          off_cnt_d = CNT_ONE;
          state_d   = LOW;
        end else if (on_cnt_q == CNT_MAX) begin
          sat_hit = 1'b1;
        end else begin
          on_cnt_d = on_cnt_q + CNT_ONE;
        end
      end
      LOW: begin
        if (rise) begin
          on_dur_d  = on_cnt_q;
          off_dur_d = off_cnt_q;
          valid_d   = 1'b1;
          on_cnt_d  = CNT_ONE;
          state_d   = HIGH;
        end else if (off_cnt_q == CNT_MAX) begin
          sat_hit = 1'b1;
        end else begin
          off_cnt_d = off_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = WAIT_RISE;
      end
    endcase

    overflow_d = overflow_q | sat_hit;
    stuck_d    = (idle_cnt_d >= TIMEOUT_C);

    if (i_clear) begin
      state_d    = WAIT_RISE;
      on_cnt_d   = '0;
      off_cnt_d  = '0;
      idle_cnt_d = '0;
      on_dur_d   = on_dur_q;
      off_dur_d  = off_dur_q;
      valid_d    = 1'b0;
      overflow_d = 1'b0;
      stuck_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= WAIT_RISE;
      on_cnt_q   <= '0;
      off_cnt_q  <= '0;
      idle_cnt_q <= '0;
      on_dur_q   <= '0;
      off_dur_q  <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      on_cnt_q   <= on_cnt_d;
      off_cnt_q  <= off_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      on_dur_q   <= on_dur_d;
      off_dur_q  <= off_dur_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      stuck_q    <= stuck_d;
    end
  end

  assign o_on_duration  = on_dur_q;
  assign o_off_duration = off_dur_q;
  assign o_valid        = valid_q;
  assign o_overflow     = overflow_q;
  assign o_stuck        = stuck_q;

endmodule

// File: tb/tb_square_wave_meas.sv
// Scoreboard bench: stimulus is a list of high/low run lengths; expected
// (on, off, spacing) tuples are derived from the run lengths and checked by a monitor on o_valid.
module tb_square_wave_meas;

  localparam int W    = 5;
  localparam int TO   = 20;
  localparam int SS   = 2;
  localparam int CMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         din;
  logic         clr;
  logic [W-1:0] on_d;
  logic [W-1:0] off_d;
  logic         valid;
  logic         ovf;
  logic         stuck;

  always #5 clk = ~clk;

  square_wave_meas #(
    .WIDTH      (W),
    .SYNC_STAGES(SS),
    .TIMEOUT    (TO)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_data        (din),
    .i_clear       (clr),
    .o_on_duration (on_d),
    .o_off_duration(off_d),
    .o_valid       (valid),
    .o_overflow    (ovf),
    .o_stuck       (stuck)
  );

  typedef struct {
    int on;
    int off;
    int gap;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   hq[$];
  int   lq[$];
  int   tests       = 0;
  int   fails       = 0;
  int   cyc         = 0;
  int   last_strobe = 0;
  int   last_on     = 0;
  int   last_off    = 0;
  bit   prev_ovf    = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== 32'(exp)) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst !== 1'b1 && valid === 1'b1) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL spurious_valid: got strobe on=%0d off=%0d expected none at cycle %0d",
                 on_d, off_d, cyc);
      end else begin
        mon_e = expq.pop_front();
        check("on_duration", 32'(on_d), mon_e.on);
        check("off_duration", 32'(off_d), mon_e.off);
        if (mon_e.gap > 0) check("strobe_spacing", 32'(cyc - last_strobe), mon_e.gap);
      end
      last_strobe = cyc;
    end
  end

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic int rand_len();
    if ($urandom_range(0, 9) < 7) return int'($urandom_range(1, 12));
    return int'($urandom_range(20, 40));
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs hq[0], lq[0], ..., hq[n] starting from a settled low input, then a low tail.
  task automatic episode(input bit do_clear, input int tail);
    int n;
    bit exp_ovf;
    bit long_prev;
    n         = lq.size();
    exp_ovf   = 1'b0;
    long_prev = 1'b0;
    din       = 1'b0;
    cycles(6);
    check("overflow_sticky", 32'(ovf), int'(prev_ovf));
    if (do_clear) begin
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      check("overflow_after_clear", 32'(ovf), 0);
      check("stuck_after_clear", 32'(stuck), 0);
    end
    for (int i = 0; i < n; i++) begin
      expq.push_back('{sat(hq[i]), sat(lq[i]), (i == 0) ? 0 : hq[i] + lq[i]});
      last_on  = sat(hq[i]);
      last_off = sat(lq[i]);
      if (hq[i] > CMAX || lq[i] > CMAX) exp_ovf = 1'b1;
    end
    if (hq[n] > CMAX || tail >= 40) exp_ovf = 1'b1;
    for (int i = 0; i <= n; i++) begin
      din = 1'b1;
      if (long_prev) begin
        cycles(2);
        check("stuck_hold_at_rise", 32'(stuck), 1);
        cycles(1);
        check("stuck_drop_after_rise", 32'(stuck), 0);
        cycles(hq[i] - 3);
      end else begin
        cycles(hq[i]);
      end
      if (i < n) begin
        din       = 1'b0;
        long_prev = (lq[i] >= TO + 6);
        if (long_prev) begin
          cycles(TO + 2);
          check("stuck_not_yet", 32'(stuck), 0);
          cycles(1);
          check("stuck_rise", 32'(stuck), 1);
          cycles(lq[i] - TO - 3);
        end else begin
          cycles(lq[i]);
        end
      end
    end
    din = 1'b0;
    cycles(tail);
    check("overflow_end", 32'(ovf), int'(exp_ovf));
    check("stuck_end", 32'(stuck), int'(tail >= 40));
    check("on_hold", 32'(on_d), last_on);
    check("off_hold", 32'(off_d), last_off);
    check("missing_strobes", 32'(expq.size()), 0);
    prev_ovf = exp_ovf;
    hq.delete();
    lq.delete();
  endtask

  initial begin
    int n;
    int h;
    rst = 1'b1;
    din = 1'b0;
    clr = 1'b0;
    #12;
    check("rst_on", 32'(on_d), 0);
    check("rst_off", 32'(off_d), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_overflow", 32'(ovf), 0);
    check("rst_stuck", 32'(stuck), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // High 3, low 6: every strobe (3,6), spaced 9 cycles.
    hq = {3, 3, 3, 3, 3};
    lq = {6, 6, 6, 6};
    episode(1'b1, 6);

    // 1-cycle high, 1-cycle low.
    hq = {1, 1, 1, 1, 1, 1, 1, 1, 1};
    lq = {1, 1, 1, 1, 1, 1, 1, 1};
    episode(1'b1, 6);

    // Saturated high phase, then saturated low phase.
    hq = {40, 3};
    lq = {5};
    episode(1'b1, 6);
    hq = {4, 3};
    lq = {45};
    episode(1'b1, 6);

    // Long low phase exercises stuck assert/deassert timing; long tail leaves it stuck.
    hq = {4, 5};
    lq = {30};
    episode(1'b1, 50);

    // Clear coinciding with a detected rise in LOW: no strobe, back to WAIT_RISE.
    din = 1'b0;
    cycles(6);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    expq.push_back('{4, 5, 0});
    expq.push_back('{3, 4, 0});
    din = 1'b1; cycles(4);
    din = 1'b0; cycles(5);
    din = 1'b1; cycles(3);
    din = 1'b0; cycles(5);
    din = 1'b1; cycles(2);
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    check("clr_rise_on_hold", 32'(on_d), 4);
    check("clr_rise_off_hold", 32'(off_d), 5);
    cycles(3);
    din = 1'b0; cycles(5);
    din = 1'b1; cycles(3);
    din = 1'b0; cycles(4);
    din = 1'b1; cycles(2);
    din = 1'b0; cycles(6);
    check("clr_rise_strobes", 32'(expq.size()), 0);
    check("clr_rise_on_final", 32'(on_d), 3);
    check("clr_rise_off_final", 32'(off_d), 4);
    last_on  = 3;
    last_off = 4;
    prev_ovf = 1'b0;

    // Asynchronous reset in the middle of a high phase.
    clr = 1'b1;
    cycles(1);
    clr = 1'b0;
    din = 1'b1;
    cycles(5);
    #3 rst = 1'b1;
    #1;
    check("async_rst_on", 32'(on_d), 0);
    check("async_rst_off", 32'(off_d), 0);
    check("async_rst_valid", 32'(valid), 0);
    check("async_rst_overflow", 32'(ovf), 0);
    check("async_rst_stuck", 32'(stuck), 0);
    din = 1'b0;
    cycles(3);
    rst      = 1'b0;
    last_on  = 0;
    last_off = 0;
    hq = {5, 4};
    lq = {7};
    episode(1'b0, 6);

    // Randomized periods.
    for (int ep = 0; ep < 14; ep++) begin
      n = int'($urandom_range(1, 4));
      for (int i = 0; i <= n; i++) begin
        h = rand_len();
        if (i > 0 && lq[i-1] >= TO + 6 && h < 3) h = 3;
        hq.push_back(h);
        if (i < n) lq.push_back(rand_len());
      end
      episode(1'b1, ($urandom_range(0, 3) == 0) ? 50 : 6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
